// File: rtl/fifo_ctrl_param.sv
// Purpose : pointer/level/flag controller for a cyclic FIFO RAM of any depth >= 2.
// Latency : accepted push visible on pop_valid_out / level_out one cycle later.
// Backpr. : push_grant_out low in FULL (and RESET); pop_valid_out low in EMPTY (and RESET).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush_in           synchronous flush to EMPTY (ignored in RESET)
//   push_valid_in      producer request;  push_grant_out  space available
//   pop_grant_in       consumer request;  pop_valid_out   head word valid
//   wr_en_out/wr_addr  RAM write strobe and address
//   rd_en_out/rd_addr  pop-accepted strobe and head address
//   level_out          occupancy 0..FIFO_DEPTH
//   almost_full_out    level >= AF_THRESH
//   almost_empty_out   level <= AE_THRESH
//   ovf_err_out, udf_err_out  sticky misuse flags, only with FIFO_CTRL_ERR_EN defined
`timescale 1ns/1ps
module fifo_ctrl_param #(
  parameter int FIFO_DEPTH  = 5,
  parameter int ADDR_WIDTH  = $clog2(FIFO_DEPTH),
  parameter int LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1),
  parameter int AF_THRESH   = FIFO_DEPTH - 1,
  parameter int AE_THRESH   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_in,
  input  logic                   push_valid_in,
  output logic                   push_grant_out,
  input  logic                   pop_grant_in,
  output logic                   pop_valid_out,
  output logic                   wr_en_out,
  output logic                   rd_en_out,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [LEVEL_WIDTH-1:0] level_out,
  output logic                   almost_full_out,
  output logic                   almost_empty_out
`ifdef FIFO_CTRL_ERR_EN
  ,
  output logic                   ovf_err_out,
  output logic                   udf_err_out
`endif
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_EMPTY  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_FULL   = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0]  PTR_LAST = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [LEVEL_WIDTH-1:0] LVL_FULL = LEVEL_WIDTH'(FIFO_DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] LVL_AF   = LEVEL_WIDTH'(AF_THRESH);
  localparam logic [LEVEL_WIDTH-1:0] LVL_AE   = LEVEL_WIDTH'(AE_THRESH);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_wr_ptr;
  logic [ADDR_WIDTH-1:0]  r_rd_ptr;
  logic [LEVEL_WIDTH-1:0] r_level;
  logic [ADDR_WIDTH-1:0]  w_wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0]  w_rd_ptr_nxt;
  logic [LEVEL_WIDTH-1:0] w_level_nxt;
  logic [ADDR_WIDTH-1:0]  w_wr_ptr_inc;
  logic [ADDR_WIDTH-1:0]  w_rd_ptr_inc;
  logic                   w_push_acc;
  logic                   w_pop_acc;

  // Moore handshake outputs
  assign push_grant_out = (r_state == ST_EMPTY) || (r_state == ST_ACTIVE);
  assign pop_valid_out  = (r_state == ST_ACTIVE) || (r_state == ST_FULL);

  assign w_push_acc = push_valid_in & push_grant_out;
  assign w_pop_acc  = pop_grant_in & pop_valid_out;

  // Strobes are suppressed during a flush so the RAM never sees a write that is discarded
  assign wr_en_out = w_push_acc & ~flush_in;
  assign rd_en_out = w_pop_acc & ~flush_in;

  assign wr_addr          = r_wr_ptr;
  assign rd_addr          = r_rd_ptr;
  assign level_out        = r_level;
  assign almost_full_out  = (r_level >= LVL_AF);
  assign almost_empty_out = (r_level <= LVL_AE);

  // Explicit wrap so non-power-of-2 depths work
  assign w_wr_ptr_inc = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + ADDR_WIDTH'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + ADDR_WIDTH'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_level_nxt  = r_level;
    if (r_state == ST_RESET) begin
      // Flush is ignored here; no handshake can be accepted in RESET
      w_state_nxt = ST_EMPTY;
    end else if (flush_in) begin
      w_state_nxt  = ST_EMPTY;
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_level_nxt  = '0;
    end else begin
      if (w_push_acc) w_wr_ptr_nxt = w_wr_ptr_inc;
      if (w_pop_acc)  w_rd_ptr_nxt = w_rd_ptr_inc;
      case ({w_push_acc, w_pop_acc})
        2'b10:   w_level_nxt = r_level + LEVEL_WIDTH'(1);
        2'b01:   w_level_nxt = r_level - LEVEL_WIDTH'(1);
        default: w_level_nxt = r_level;
      endcase
      // Transitions look at the post-update level
      case (r_state)
        ST_EMPTY:  if (w_push_acc) w_state_nxt = ST_ACTIVE;
        ST_ACTIVE: begin
          if (w_level_nxt == LVL_FULL)  w_state_nxt = ST_FULL;
          else if (w_level_nxt == '0)   w_state_nxt = ST_EMPTY;
        end
        ST_FULL:   if (w_pop_acc) w_state_nxt = ST_ACTIVE;
        default:   w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RESET;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic r_ovf_err;
  logic r_udf_err;

  // Sticky misuse flags; flush clears and wins over a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else if (flush_in) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      r_ovf_err <= r_ovf_err | (push_valid_in & (r_state == ST_FULL));
      r_udf_err <= r_udf_err | (pop_grant_in & (r_state == ST_EMPTY));
    end
  end

  assign ovf_err_out = r_ovf_err;
  assign udf_err_out = r_udf_err;
`endif

endmodule

// File: tb/tb_fifo_ctrl_param.sv
`timescale 1ns/1ps
module tb_fifo_ctrl_param;

  localparam int D  = 5;
  localparam int AW = $clog2(D);
  localparam int LW = $clog2(D + 1);
  localparam int AF = D - 1;
  localparam int AE = 1;
  localparam int OW = 6 + 2 * AW + LW;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_in, push_valid_in, pop_grant_in;
  logic push_grant_out, pop_valid_out, wr_en_out, rd_en_out;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [LW-1:0] level_out;
  logic almost_full_out, almost_empty_out;
`ifdef FIFO_CTRL_ERR_EN
  logic ovf_err_out, udf_err_out;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_ctrl_param #(
    .FIFO_DEPTH(D), .ADDR_WIDTH(AW), .LEVEL_WIDTH(LW), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_in(flush_in),
    .push_valid_in(push_valid_in), .push_grant_out(push_grant_out),
    .pop_grant_in(pop_grant_in), .pop_valid_out(pop_valid_out),
    .wr_en_out(wr_en_out), .rd_en_out(rd_en_out),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .level_out(level_out),
    .almost_full_out(almost_full_out), .almost_empty_out(almost_empty_out)
`ifdef FIFO_CTRL_ERR_EN
    , .ovf_err_out(ovf_err_out), .udf_err_out(udf_err_out)
`endif
  );

  // Reference model: total accepted pushes/pops since the last flush or reset.
  bit m_ready;   // first clock after reset release has happened
  int m_w, m_r;
  bit m_ovf, m_udf;

  function automatic void model_reset();
    m_ready = 0; m_w = 0; m_r = 0; m_ovf = 0; m_udf = 0;
  endfunction

  // Output vector order: grant, valid, wr_en, rd_en, wr_addr, rd_addr, level, af, ae
  function automatic logic [OW-1:0] pack(bit g, bit v, bit we, bit re, int wa, int ra,
                                         int lv, bit af, bit ae);
    logic [AW-1:0] a_w, a_r;
    logic [LW-1:0] l;
    a_w = AW'(wa); a_r = AW'(ra); l = LW'(lv);
    return {g, v, we, re, a_w, a_r, l, af, ae};
  endfunction

  function automatic logic [OW-1:0] model_out(bit f, bit p, bit q);
    int lvl;
    bit g, v;
    lvl = m_w - m_r;
    g = m_ready && (lvl < D);
    v = m_ready && (lvl > 0);
    return pack(g, v, p && g && !f, q && v && !f, m_w % D, m_r % D, lvl,
                lvl >= AF, lvl <= AE);
  endfunction

  function automatic void model_clock(bit f, bit p, bit q);
    int lvl;
    bit g, v;
    lvl = m_w - m_r;
    g = m_ready && (lvl < D);
    v = m_ready && (lvl > 0);
    if (f) begin
      m_ovf = 0; m_udf = 0;
    end else begin
      if (p && m_ready && lvl == D) m_ovf = 1;
      if (q && m_ready && lvl == 0) m_udf = 1;
    end
    if (!m_ready) m_ready = 1;
    else if (f) begin
      m_w = 0; m_r = 0;
    end else begin
      if (p && g) m_w++;
      if (q && v) m_r++;
    end
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {push_grant_out, pop_valid_out, wr_en_out, rd_en_out,
            wr_addr, rd_addr, level_out, almost_full_out, almost_empty_out};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] exp);
    logic [OW-1:0] act;
    act = dut_out();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t: got g/v/we/re/wa/ra/lvl/af/ae=%b expected %b",
               name, $time, act, exp);
    end
  endtask

`ifdef FIFO_CTRL_ERR_EN
  task automatic check_err(input string name);
    tests++;
    if ({ovf_err_out, udf_err_out} !== {m_ovf, m_udf}) begin
      fails++;
      $display("FAIL %s t=%0t: got ovf/udf=%b%b expected %b%b", name, $time,
               ovf_err_out, udf_err_out, m_ovf, m_udf);
    end
  endtask
`endif

  // Caller is positioned at a negedge; returns at the next negedge.
  task automatic step(input string name, input bit f, input bit p, input bit q);
    flush_in = f; push_valid_in = p; pop_grant_in = q;
    #1;
    check(name, model_out(f, p, q));
`ifdef FIFO_CTRL_ERR_EN
    check_err({name, "_err"});
`endif
    @(posedge clk);
    model_clock(f, p, q);
    @(negedge clk);
  endtask

  typedef struct {
    bit f, p, q;
    logic [OW-1:0] exp;
  } vec_t;

  function automatic vec_t mkv(bit f, bit p, bit q, bit g, bit v, bit we, bit re,
                               int wa, int ra, int lv, bit af, bit ae);
    vec_t t;
    t.f = f; t.p = p; t.q = q;
    t.exp = pack(g, v, we, re, wa, ra, lv, af, ae);
    return t;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[15];
    int pp, qp;
    bit rf, rp, rq;

    //            f p q   g v we re wa ra lv af ae
    vt[0]  = mkv(0,0,0,  0,0,0, 0, 0, 0, 0, 0, 1);  // RESET cycle
    vt[1]  = mkv(0,0,0,  1,0,0, 0, 0, 0, 0, 0, 1);  // EMPTY
    vt[2]  = mkv(0,1,0,  1,0,1, 0, 0, 0, 0, 0, 1);
    vt[3]  = mkv(0,1,0,  1,1,1, 0, 1, 0, 1, 0, 1);
    vt[4]  = mkv(0,1,0,  1,1,1, 0, 2, 0, 2, 0, 0);
    vt[5]  = mkv(0,1,0,  1,1,1, 0, 3, 0, 3, 0, 0);
    vt[6]  = mkv(0,1,0,  1,1,1, 0, 4, 0, 4, 1, 0);  // af from level 4
    vt[7]  = mkv(0,1,1,  0,1,0, 1, 0, 0, 5, 1, 0);  // FULL: only pop accepted
    vt[8]  = mkv(0,1,0,  1,1,1, 0, 0, 1, 4, 1, 0);
    vt[9]  = mkv(0,0,1,  0,1,0, 1, 1, 1, 5, 1, 0);
    vt[10] = mkv(0,0,1,  1,1,0, 1, 1, 2, 4, 1, 0);
    vt[11] = mkv(1,1,1,  1,1,0, 0, 1, 3, 3, 0, 0);  // flush beats push+pop
    vt[12] = mkv(0,0,0,  1,0,0, 0, 0, 0, 0, 0, 1);
    vt[13] = mkv(0,0,1,  1,0,0, 0, 0, 0, 0, 0, 1);  // pop on EMPTY ignored
    vt[14] = mkv(0,0,0,  1,0,0, 0, 0, 0, 0, 0, 1);

    rst_n = 1'b0; flush_in = 0; push_valid_in = 0; pop_grant_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, model kept in step for the later sequences
    for (int i = 0; i < 15; i++) begin
      flush_in = vt[i].f; push_valid_in = vt[i].p; pop_grant_in = vt[i].q;
      #1;
      check($sformatf("vec%0d", i), vt[i].exp);
      @(posedge clk);
      model_clock(vt[i].f, vt[i].p, vt[i].q);
      @(negedge clk);
    end
`ifdef FIFO_CTRL_ERR_EN
    check_err("after_table_err");
    step("ovf_fill", 1, 0, 0);
    for (int i = 0; i < D; i++) step("ovf_fill", 0, 1, 0);
    step("ovf_push_full", 0, 1, 0);
    step("ovf_flag", 0, 0, 0);
    step("ovf_flush", 1, 1, 0);
`endif

    // Steady push+pop at level 2 with address wrap
    step("wrap_fill", 0, 1, 0);
    step("wrap_fill", 0, 1, 0);
    for (int i = 0; i < 12; i++) step("wrap_steady", 0, 1, 1);
    step("wrap_end", 0, 0, 0);

    // Asynchronous reset mid-stream at level 3
    step("arst_flush", 1, 0, 0);
    for (int i = 0; i < 3; i++) step("arst_fill", 0, 1, 0);
    flush_in = 0; push_valid_in = 1; pop_grant_in = 0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_async", model_out(0, 1, 0));
`ifdef FIFO_CTRL_ERR_EN
    check_err("arst_async_err");
`endif
    @(posedge clk);
    @(negedge clk);
    push_valid_in = 0;
    rst_n = 1'b1;
    step("arst_rel1", 0, 0, 0);
    step("arst_rel2", 0, 0, 0);

    // Randomized traffic in phases of varying push/pop pressure
    pp = 50; qp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        pp = $urandom_range(10, 90);
        qp = $urandom_range(10, 90);
      end
      rf = ($urandom_range(0, 63) == 0);
      rp = ($urandom_range(0, 99) < pp);
      rq = ($urandom_range(0, 99) < qp);
      step("rand", rf, rp, rq);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_param.md
Name: fifo_ctrl_param

Overview:
Parametrised FIFO control unit for the FIFO datapath. It manages a cyclic storage array of arbitrary depth, including non-power-of-2 depths, through independent read and write pointers with explicit modular wrap. Beyond the basic push/pop handshake, it adds an occupancy level output, programmable almost-full and almost-empty flags, and a synchronous flush. It drives the address and enable inputs of the FIFO storage RAM and sits between the producer and consumer handshakes.

Parameters:
- FIFO_DEPTH, 5, number of storage entries; any integer >= 2.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), width of the read and write addresses.
- LEVEL_WIDTH, $clog2(FIFO_DEPTH+1), width of the occupancy count (values 0..FIFO_DEPTH).
- AF_THRESH, FIFO_DEPTH-1, almost_full asserts when level >= AF_THRESH; range 1..FIFO_DEPTH.
- AE_THRESH, 1, almost_empty asserts when level <= AE_THRESH; range 0..FIFO_DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_in  in  1  synchronous flush; empties the FIFO.
- push_valid_in  in  1  producer offers a data word.
- push_grant_out  out  1  the FIFO can accept a word this cycle.
- pop_grant_in  in  1  consumer accepts the head word.
- pop_valid_out  out  1  the head word is valid.
- wr_en_out  out  1  RAM write strobe.
- rd_en_out  out  1  pop-accepted strobe.
- wr_addr  out  ADDR_WIDTH  RAM write address.
- rd_addr  out  ADDR_WIDTH  RAM read address (head of the FIFO).
- level_out  out  LEVEL_WIDTH  current occupancy.
- almost_full_out  out  1  level >= AF_THRESH.
- almost_empty_out  out  1  level <= AE_THRESH.

Behaviour:
- Registered state: state ∈ {RESET, EMPTY, ACTIVE, FULL}, wr_ptr, rd_ptr, level.
  - On rst_n=0, immediately: state=RESET and wr_ptr=rd_ptr=level=0.
  - All outputs are then 0, except almost_empty_out, which is 1 because AE_THRESH >= 0.
- Moore outputs, decoded from the registered state:
  - push_grant_out = state ∈ {EMPTY, ACTIVE}.
  - pop_valid_out = state ∈ {ACTIVE, FULL}.
  - wr_addr = wr_ptr; rd_addr = rd_ptr; level_out = level; the flags are compares on the registered level.
- Handshake qualifiers (combinational):
  - push_acc = push_valid_in & push_grant_out.
  - pop_acc = pop_grant_in & pop_valid_out.
  - wr_en_out = push_acc & ~flush_in; rd_en_out = pop_acc & ~flush_in.
  - A push request without a grant, or a pop request without valid, is ignored and changes no state.
- Pointer update:
  - Each pointer advances by 1 on its accepted operation.
  - If a pointer equals FIFO_DEPTH-1, it wraps to 0 explicitly. No reliance on power-of-2 wrap.
- Level update:
  - +1 on push_acc only; -1 on pop_acc only.
  - Unchanged on both or neither.
- Transitions, evaluated on the next level value:
  - RESET -> EMPTY unconditionally after the first clock following reset release. push_grant_out rises in that cycle.
  - EMPTY -> ACTIVE on push_acc.
  - ACTIVE -> FULL when the next level = FIFO_DEPTH.
  - ACTIVE -> EMPTY when the next level = 0.
  - Simultaneous push and pop in ACTIVE keeps ACTIVE with level unchanged; both pointers advance.
  - FULL -> ACTIVE on pop_acc. A concurrent push_valid_in is not granted in FULL.
- Flush:
  - flush_in=1 in EMPTY, ACTIVE or FULL: next state=EMPTY, wr_ptr=rd_ptr=level=0.
  - Flush has priority over any concurrent push or pop, and wr_en_out/rd_en_out are held 0 that cycle.
  - In RESET, flush_in is ignored; the block goes to EMPTY as normal.
- Latency: an accepted push is visible on pop_valid_out and level_out 1 cycle later.
- Reset mid-operation: asynchronous return to RESET and zeroed pointers; stored contents are treated as lost.
- Invariant: (wr_ptr - rd_ptr) mod FIFO_DEPTH == level mod FIFO_DEPTH at all times.

Optional Feature:
FIFO_CTRL_ERR_EN
- When defined, adds outputs ovf_err_out and udf_err_out (1 bit each).
  - ovf_err_out sets sticky when push_valid_in=1 while state=FULL.
  - udf_err_out sets sticky when pop_grant_in=1 while state=EMPTY.
  - Both clear on reset or flush_in. Flush wins over a same-cycle set.
  - Both are registered: the flag rises 1 cycle after the offending request.
- When not defined, these ports and their logic do not exist, and out-of-handshake requests are silently ignored.

Test Plan:
- Reset release, then idle 2 cycles -> cycle 1: push_grant=0, pop_valid=0. Cycle 2: push_grant=1, level=0, almost_empty=1.
- FIFO_DEPTH=5: 5 consecutive pushes -> wr_addr 0,1,2,3,4. Then state FULL, push_grant=0, level=5, almost_full=1 from level 4.
- FIFO_DEPTH=5: continuous push+pop for 12 cycles at level 2 -> level stays 2; rd_addr sequence wraps 4->0; no FULL or EMPTY entry.
- At level 3, assert flush_in together with push_valid_in and pop_grant_in -> wr_en_out=rd_en_out=0; next cycle level=0, EMPTY, both addresses 0.
- In FULL, push_valid_in=1 and pop_grant_in=1 -> only the pop is accepted; next level=4, state ACTIVE. With FIFO_CTRL_ERR_EN, ovf_err_out=1 next cycle.
- Drop rst_n mid-stream at level 3 -> outputs zero asynchronously within the same cycle; the power-up sequence then repeats.
